alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 133 +++++++++++++
 tb/tb_alu_exec_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - ALU execute unit with valid/ready handshake and 1-bit/cycle shifter
// Non-shift ops finish at the accepting edge; shifts by N>0 iterate one bit per cycle.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_control,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] OP_OR   = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1100;

  // Shift kind is alu_control[2:1]: SLL=00, SRL=01, SRA=10.
  localparam logic [1:0] K_SLL = 2'b00;
  localparam logic [1:0] K_SRL = 2'b01;

  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  kind_q, kind_d;

  logic [31:0] alu_res;
  logic [31:0] shift_step;
  logic        is_shift;
  logic [4:0]  shamt;

  assign shamt    = operand_b[4:0];
  assign is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                    (alu_control == OP_SRA);

  // Shift codes pass operand_a through; that value is only kept when shamt is 0.
  always_comb begin
    alu_res = 32'd0;
    case (alu_control)
      OP_OR:   alu_res = operand_a | operand_b;
      OP_SLL:  alu_res = operand_a;
      OP_ADD:  alu_res = operand_a + operand_b;
      OP_SRL:  alu_res = operand_a;
      OP_XOR:  alu_res = operand_a ^ operand_b;
      OP_SRA:  alu_res = operand_a;
      OP_SUB:  alu_res = operand_a - operand_b;
      OP_SLT:  alu_res = {31'd0, $signed(operand_a) < $signed(operand_b)};
      OP_SLTU: alu_res = {31'd0, operand_a < operand_b};
      OP_AND:  alu_res = operand_a & operand_b;
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    shift_step = {result_q[31], result_q[31:1]};
    if (kind_q == K_SLL) begin
      shift_step = {result_q[30:0], 1'b0};
    end else if (kind_q == K_SRL) begin
      shift_step = {1'b0, result_q[31:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_shift && (shamt != 5'd0)) begin
            result_d = operand_a;
            cnt_d    = shamt;
            kind_d   = alu_control[2:1];
            state_d  = S_SHIFT;
          end else begin
            result_d = alu_res;
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        result_d = shift_step;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= 32'd0;
      cnt_q    <= 5'd0;
      kind_q   <= K_SLL;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = (result_q == 32'd0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure latency to out_valid, hold for 'hold' cycles under
  // backpressure with junk requests, then consume with in_valid still high.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int hold);
    int lat;
    int busy_viol;
    chk({tag, ".idle_ready"}, {31'd0, in_ready}, 32'd1);
    alu_control = op;
    operand_a   = a;
    operand_b   = b;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
    operand_a   = ~a;
    operand_b   = ~b;
    alu_control = ~op;
    lat       = 1;
    busy_viol = 0;
    while (!out_valid && lat < 64) begin
      if (in_ready) busy_viol++;
      tick();
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
    chk({tag, ".busy_not_ready"}, busy_viol, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      operand_a = 32'h1234_5678 + i;
      out_ready = 1'b0;
      tick();
      chk({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".hold_result"}, result, exp_res);
      chk({tag, ".hold_zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, ".after_handoff_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, ".after_handoff_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = 4'd0; operand_a = 32'd0; operand_b = 32'd0;
    tick(); tick();
    rst = 1'b0;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.zero", {31'd0, zero}, 32'd1);

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_out_ready.in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_out_ready.out_valid", {31'd0, out_valid}, 32'd0);

    run_op("add_wrap",  4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0);
    run_op("sra4",      4'b0101, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5, 0);
    run_op("slt",       4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 0);
    run_op("sltu",      4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0);
    run_op("sub_bp",    4'b0110, 32'd5,         32'd5,         32'h0000_0000, 1, 3);
    run_op("sub_wrap",  4'b0110, 32'd0,         32'd1,         32'hFFFF_FFFF, 1, 0);
    run_op("or",        4'b0000, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1, 0);
    run_op("xor",       4'b0100, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1, 0);
    run_op("and",       4'b1100, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1, 0);
    run_op("bad_code",  4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
    run_op("sll_sh0",   4'b0001, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1, 0);
    run_op("sll31",     4'b0001, 32'h0000_0001, 32'd31,        32'h8000_0000, 32, 0);
    run_op("sll_hi",    4'b0001, 32'h8000_0003, 32'h0000_0021, 32'h0000_0006, 2, 0);
    run_op("srl31",     4'b0011, 32'h8000_0000, 32'd31,        32'h0000_0001, 32, 0);
    run_op("srl3",      4'b0011, 32'hF000_0000, 32'd3,         32'h1E00_0000, 4, 0);
    run_op("sra_pos",   4'b0101, 32'h4000_0000, 32'd2,         32'h1000_0000, 3, 0);

    // Abandon an SRL by 20 with reset three cycles after acceptance.
    alu_control = 4'b0011;
    operand_a   = 32'hFFFF_FFFF;
    operand_b   = 32'd20;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("rst_mid.busy", {31'd0, in_ready}, 32'd0);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid.result", result, 32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rst_mid.no_result", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
